serial_addsub: RTL and testbench
================================

// Module: serial_addsub
// PURPOSE
//  Parametrised multi-cycle adder/subtractor: WIDTH-bit operands processed
//  DIGIT_W bits per cycle, LSB digit first, through one DIGIT_W-bit
//  full-adder ripple slice. Valid/ready on both sides; area-lean arithmetic
//  unit for datapaths that trade latency for gates.
//  Adds subtract mode, borrow-in, signed overflow and flow control.
// PARAMETERS
//  WIDTH    16  operand/result width in bits
//  DIGIT_W  4   bits processed per cycle; WIDTH % DIGIT_W == 0 (elaboration error otherwise)
//  (local) NUM_DIG = WIDTH/DIGIT_W  cycles in RUN; DIG_CNT_W = max(1,$clog2(NUM_DIG))
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands valid
//  in_ready   out  1      block accepts operands (high only in IDLE)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (add) / borrow-in (sub)
//  sub        in   1      0: a+b+cin   1: a-b-cin
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  result, modulo 2^WIDTH
//  cout       out  1      final carry; in sub mode 1 = no borrow
//  ovf        out  1      two's-complement overflow
// BEHAVIOUR
//  - Reset (rst_n low, async): state=IDLE, digit counter=0, operand/result
//    regs=0; sum=0, cout=0, ovf=0, out_valid=0, in_ready=1 (state decode).
//    Reset mid-RUN/DONE aborts the operation; no result is emitted.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//    IDLE: in_ready=1. On in_valid: capture a, b_eff = sub ? ~b : b,
//      carry = cin ^ sub; counter=0; go RUN.
//    RUN: each cycle add digit[counter] of a and b_eff with carry; shift
//      DIGIT_W sum bits into result reg from the top; carry <= slice cout.
//      At counter==NUM_DIG-1: cout <= slice cout,
//      ovf <= slice cout ^ carry into bit WIDTH-1; go DONE.
//    DONE: out_valid=1; sum/cout/ovf stable. On out_ready go IDLE.
//  - Latency: accept edge T; out_valid high after edge T+NUM_DIG (NUM_DIG=1
//    when DIGIT_W==WIDTH). Throughput: one op per NUM_DIG+2 cycles minimum.
//  - in_valid ignored outside IDLE; in_ready=0 in RUN and DONE, including
//    the DONE cycle where out_ready is sampled (no same-cycle turnaround).
//  - out_ready ignored outside DONE. a/b/cin/sub may change freely after
//    acceptance.
//  - sum/cout/ovf hold the last result after handshake until the next
//    result lands; out_valid is the only qualifier.
//  - Counter wraps to 0 on leaving RUN; no state beyond NUM_DIG-1 reachable.
//  - All outputs registered or decoded from state reg only; no
//    combinational path from inputs to outputs.
// STRUCTURE
//  - Package serial_addsub_pkg: state typedef (IDLE, RUN, DONE, 2-bit
//    encoding 00/01/10), state-width constant.
//  - Sub-module addsub_digit #(DIGIT_W): purely combinational ripple of
//    full adders; ports a_d, b_d, ci -> s_d, co, c_msb (carry into top bit,
//    used for ovf).
//  - Top holds the FSM, digit counter, operand shift regs, result reg.
// TESTING  (WIDTH=16, DIGIT_W=4 unless noted)
//  1 add 0x1234+0x0001 cin=0 -> sum=0x1235 cout=0 ovf=0; out_valid exactly
//    4 cycles after accept edge.
//  2 add 0xFFFF+0x0001 -> 0x0000 cout=1 ovf=0; add 0x7FFF+0x0001 -> 0x8000
//    cout=0 ovf=1.
//  3 sub 0x0005-0x0007 cin=0 -> 0xFFFE cout=0 ovf=0; sub 0x8000-0x0001 ->
//    0x7FFF cout=1 ovf=1; sub 0x0010-0x0001 cin=1 -> 0x000E cout=1.
//  4 out_ready low 10 cycles in DONE -> out_valid, sum, cout, ovf stable,
//    in_ready=0, in_valid pulses ignored; release -> in_ready=1 next cycle.
//  5 rst_n low during RUN digit 2 -> outputs 0, in_ready=1 immediately
//    (async); after release, next op runs correctly.
//  6 DIGIT_W=16 and DIGIT_W=1: random add/sub vs reference model,
//    latencies 1 and 16 cycles respectively.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// Shared types for the digit-serial adder/subtractor.
package serial_addsub_pkg;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;
endpackage

// File: rtl/addsub_digit.sv
// One DIGIT_W-bit ripple-carry slice; also exposes the carry into its top bit
// so the caller can form signed overflow on the most significant digit.
module addsub_digit #(
  parameter int DIGIT_W = 4
) (
  input  logic [DIGIT_W-1:0] a_d,
  input  logic [DIGIT_W-1:0] b_d,
  input  logic               ci,
  output logic [DIGIT_W-1:0] s_d,
  output logic               co,
  output logic               c_msb
);
  logic [DIGIT_W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT_W; i++) begin : g_fa
    assign s_d[i]   = a_d[i] ^ b_d[i] ^ c[i];
    assign c[i+1]   = (a_d[i] & b_d[i]) | (c[i] & (a_d[i] ^ b_d[i]));
  end

  assign co    = c[DIGIT_W];
  assign c_msb = c[DIGIT_W-1];
endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle add/sub: WIDTH-bit operands consumed DIGIT_W bits per cycle,
// LSB digit first, through a single addsub_digit slice. Valid/ready both sides.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DIGIT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NUM_DIG   = WIDTH / DIGIT_W;
  localparam int DIG_CNT_W = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
  localparam logic [DIG_CNT_W-1:0] LAST_DIG = DIG_CNT_W'(NUM_DIG - 1);

  if (WIDTH % DIGIT_W != 0) begin : g_bad_digit_w
    $error("serial_addsub: WIDTH must be a multiple of DIGIT_W");
  end

  state_t               state, state_nxt;
  logic [DIG_CNT_W-1:0] cnt;
  logic [WIDTH-1:0]     a_r, b_r, res_r, res_nxt;
  logic                 carry;
  logic [DIGIT_W-1:0]   s_d;
  logic                 co, c_msb;
  logic                 last;

  // Operands shift right each RUN cycle, so the active digit is always at bit 0.
  addsub_digit #(.DIGIT_W(DIGIT_W)) u_digit (
    .a_d   (a_r[DIGIT_W-1:0]),
    .b_d   (b_r[DIGIT_W-1:0]),
    .ci    (carry),
    .s_d   (s_d),
    .co    (co),
    .c_msb (c_msb)
  );

  assign last    = (cnt == LAST_DIG);
  assign res_nxt = (res_r >> DIGIT_W) | (WIDTH'(s_d) << (WIDTH - DIGIT_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      res_r <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          // Subtraction as a + ~b + ~cin; carry-out then means "no borrow".
          a_r   <= a;
          b_r   <= sub ? ~b : b;
          carry <= cin ^ sub;
          cnt   <= '0;
        end
        RUN: begin
          a_r   <= a_r >> DIGIT_W;
          b_r   <= b_r >> DIGIT_W;
          res_r <= res_nxt;
          carry <= co;
          if (last) begin
            cnt  <= '0;
            sum  <= res_nxt;
            cout <= co;
            ovf  <= co ^ c_msb;
          end else begin
            cnt  <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: three instances (DIGIT_W = 4, 16, 1) driven with
// directed and random ops, checked against an integer-arithmetic model.
module tb_serial_addsub;
  logic        clk;
  logic        rst_n;
  logic [2:0]  in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a [3];
  logic [15:0] b [3];
  logic [15:0] sum [3];

  int checks = 0;
  int errors = 0;
  int ndig [3] = '{4, 1, 16};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(16), .DIGIT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .cin(cin[0]), .sub(sub[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .sum(sum[0]), .cout(cout[0]), .ovf(ovf[0]));

  serial_addsub #(.WIDTH(16), .DIGIT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1]), .b(b[1]), .cin(cin[1]), .sub(sub[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .sum(sum[1]), .cout(cout[1]), .ovf(ovf[1]));

  serial_addsub #(.WIDTH(16), .DIGIT_W(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a[2]), .b(b[2]), .cin(cin[2]), .sub(sub[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .sum(sum[2]), .cout(cout[2]), .ovf(ovf[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned and signed views.
  function automatic void model(input logic [15:0] av, input logic [15:0] bv,
                                input logic ci, input logic sb,
                                output logic [15:0] s, output logic co, output logic ov);
    int ua, ub, sa, sbs, ru, rs;
    ua  = int'(av);
    ub  = int'(bv);
    sa  = int'($signed(av));
    sbs = int'($signed(bv));
    if (sb) begin
      ru = ua - ub - int'(ci);
      rs = sa - sbs - int'(ci);
      co = (ru >= 0);
    end else begin
      ru = ua + ub + int'(ci);
      rs = sa + sbs + int'(ci);
      co = ru[16];
    end
    s  = ru[15:0];
    ov = (rs > 32767) || (rs < -32768);
  endfunction

  task automatic run_op(input int k, input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, input logic sb, input int hold);
    logic [15:0] es;
    logic        ec, eo;
    int          lat;
    model(av, bv, ci, sb, es, ec, eo);
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready[k]), 32'd1);
    a[k] = av; b[k] = bv; cin[k] = ci; sub[k] = sb; in_valid[k] = 1'b1;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    a[k] = 16'($urandom); b[k] = 16'($urandom);
    cin[k] = 1'($urandom); sub[k] = 1'($urandom);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid[k] && lat < 40);
    chk("latency", 32'(lat), 32'(ndig[k]));
    chk("sum", 32'(sum[k]), 32'(es));
    chk("cout", 32'(cout[k]), 32'(ec));
    chk("ovf", 32'(ovf[k]), 32'(eo));
    // Back-pressure: result must hold and new operands must be ignored.
    for (int i = 0; i < hold; i++) begin
      in_valid[k] = 1'(i % 2);
      a[k] = 16'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid[k]), 32'd1);
      chk("hold_in_ready", 32'(in_ready[k]), 32'd0);
      chk("hold_sum", 32'(sum[k]), 32'(es));
      chk("hold_cout", 32'(cout[k]), 32'(ec));
      chk("hold_ovf", 32'(ovf[k]), 32'(eo));
    end
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
    chk("post_in_ready", 32'(in_ready[k]), 32'd1);
    chk("post_out_valid", 32'(out_valid[k]), 32'd0);
    chk("post_sum_held", 32'(sum[k]), 32'(es));
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = '0; out_ready = '0; cin = '0; sub = '0;
    for (int k = 0; k < 3; k++) begin a[k] = '0; b[k] = '0; end

    #12;
    for (int k = 0; k < 3; k++) begin
      chk("rst_sum", 32'(sum[k]), 32'd0);
      chk("rst_cout", 32'(cout[k]), 32'd0);
      chk("rst_out_valid", 32'(out_valid[k]), 32'd0);
      chk("rst_in_ready", 32'(in_ready[k]), 32'd1);
    end
    @(negedge clk); rst_n = 1'b1;

    // Directed add/sub corner cases on the 4-bit-digit instance.
    run_op(0, 16'h1234, 16'h0001, 1'b0, 1'b0, 0);
    run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op(0, 16'h0005, 16'h0007, 1'b0, 1'b1, 0);
    run_op(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 0);
    run_op(0, 16'h0010, 16'h0001, 1'b1, 1'b1, 0);
    run_op(0, 16'hABCD, 16'h1111, 1'b1, 1'b0, 10);

    // Reset during digit 2 of an op: aborted, outputs clear immediately.
    @(negedge clk);
    a[0] = 16'h4321; b[0] = 16'h1111; cin[0] = 1'b0; sub[0] = 1'b0; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sum", 32'(sum[0]), 32'd0);
    chk("arst_cout", 32'(cout[0]), 32'd0);
    chk("arst_ovf", 32'(ovf[0]), 32'd0);
    chk("arst_out_valid", 32'(out_valid[0]), 32'd0);
    chk("arst_in_ready", 32'(in_ready[0]), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_result", 32'(out_valid[0]), 32'd0);
    end
    run_op(0, 16'h8000, 16'h8000, 1'b0, 1'b0, 0);

    // Random add/sub on every digit width.
    for (int k = 0; k < 3; k++)
      for (int n = 0; n < 20; n++)
        run_op(k, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
